// File: rtl/axi4lite_sram_slave_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// channel FSM encodings, debug view and the LFSR step function.
package axi4lite_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Width of the latency down-counters; holds LAT-1 plus up to 7 random cycles.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Observation bundle so checkers can follow both FSMs and the delay source.
    typedef struct packed {
        rd_state_e   rd_state;
        wr_state_e   wr_state;
        logic [15:0] lfsr;
    } dbg_t;

    // 16-bit Fibonacci LFSR step, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

endpackage

// File: rtl/axi4lite_sram_slave_lfsr16.sv
// Free-running 16-bit LFSR used as the random latency source.
module axi4lite_sram_slave_lfsr16
    import axi4lite_sram_slave_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q, q_d;

    // advance one step every cycle
    always_comb q_d = lfsr_next(q_q);

    // state register, reloads the seed on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= SEED;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite word-organised SRAM responder with independent read and write
// channel FSMs, programmable response latency and address-range decode.
// Handshake rule: a beat transfers on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until that edge.
module axi4lite_sram_slave
    import axi4lite_sram_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    DEPTH      = 4096,
    parameter int                    RD_LAT     = 1,
    parameter int                    WR_LAT     = 1,
    parameter int                    RAND_DELAY = 0,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    input  logic                  rready,
    input  logic                  awvalid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awready,
    input  logic                  wvalid,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    output logic                  wready,
    output logic                  bvalid,
    output logic [1:0]            bresp,
    input  logic                  bready,
    output dbg_t                  dbg
);

    localparam int                    IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [15:0]      lfsr_q;
    logic [CNT_W-1:0] extra;

    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    wr_state_e             wr_state_q, wr_state_d;
    logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [3:0]            wr_strb_q, wr_strb_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [1:0]            bresp_q, bresp_d;

    logic [ADDR_WIDTH-1:0] rd_off, wr_off;
    logic                  rd_hit, wr_hit, wr_commit, aw_take, w_take;
    logic [IDX_W-1:0]      rd_idx, wr_idx;

    axi4lite_sram_slave_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // address decode of the latched addresses and per-load random extension
    always_comb begin
        extra     = (RAND_DELAY != 0) ? CNT_W'(lfsr_q[2:0]) : '0;
        rd_off    = rd_addr_q - BASE_ADDR;
        wr_off    = wr_addr_q - BASE_ADDR;
        rd_hit    = (rd_addr_q >= BASE_ADDR) && (rd_off < SPAN);
        wr_hit    = (wr_addr_q >= BASE_ADDR) && (wr_off < SPAN);
        rd_idx    = rd_off[IDX_W+1:2];
        wr_idx    = wr_off[IDX_W+1:2];
        wr_commit = (wr_state_q == W_WAIT) && (wr_cnt_q == '0) && wr_hit;
        aw_take   = awvalid && !aw_got_q;
        w_take    = wvalid && !w_got_q;
    end

    // read channel next state: accept, count down, sample memory, hold response
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: if (arvalid) begin
                rd_addr_d  = araddr;
                rd_cnt_d   = CNT_W'(RD_LAT - 1) + extra;
                rd_state_d = R_WAIT;
            end
            R_WAIT: if (rd_cnt_q == '0) begin
                rdata_d    = rd_hit ? mem[rd_idx] : '0;
                rresp_d    = rd_hit ? RESP_OKAY : RESP_DECERR;
                rd_state_d = R_RESP;
            end else begin
                rd_cnt_d = rd_cnt_q - 1'b1;
            end
            R_RESP: if (rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // write channel next state: capture AW/W independently, count down, respond
    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        wr_cnt_d   = wr_cnt_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_take) begin
                    wr_addr_d = awaddr;
                    aw_got_d  = 1'b1;
                end
                if (w_take) begin
                    wr_data_d = wdata;
                    wr_strb_d = wstrb;
                    w_got_d   = 1'b1;
                end
                if (aw_got_d && w_got_d) begin
                    wr_cnt_d   = CNT_W'(WR_LAT - 1) + extra;
                    wr_state_d = W_WAIT;
                end
            end
            W_WAIT: if (wr_cnt_q == '0) begin
                bresp_d    = wr_hit ? RESP_OKAY : RESP_DECERR;
                wr_state_d = W_RESP;
            end else begin
                wr_cnt_d = wr_cnt_q - 1'b1;
            end
            W_RESP: if (bready) begin
                aw_got_d   = 1'b0;
                w_got_d    = 1'b0;
                wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // state and datapath registers for both channels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            wr_state_q <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            wr_cnt_q   <= '0;
            bresp_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_state_q <= wr_state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            wr_cnt_q   <= wr_cnt_d;
            bresp_q    <= bresp_d;
        end
    end

    // byte-masked commit; a same-cycle read samples the pre-write word
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb_q[i]) mem[wr_idx][8*i +: 8] <= wr_data_q[8*i +: 8];
            end
        end
    end

    // outputs: readies are forced low while reset is asserted
    always_comb begin
        arready      = rst && (rd_state_q == R_IDLE);
        awready      = rst && (wr_state_q == W_IDLE) && !aw_got_q;
        wready       = rst && (wr_state_q == W_IDLE) && !w_got_q;
        rvalid       = (rd_state_q == R_RESP);
        rdata        = rdata_q;
        rresp        = rresp_q;
        bvalid       = (wr_state_q == W_RESP);
        bresp        = bresp_q;
        dbg.rd_state = rd_state_q;
        dbg.wr_state = wr_state_q;
        dbg.lfsr     = lfsr_q;
    end

endmodule
